// File: rtl/sim_test_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sim_test_controller_pkg
//  Description : Shared types and constants for the simulation/test-harness
//                controller: verdict status codes, FSM state encoding and
//                the word-address helper used by the bus snoop.
//  Revision    : 1.0  initial release
// ============================================================================
package sim_test_controller_pkg;

    // Verdict codes reported on the status output
    localparam logic [2:0] SIM_ST_RUNNING = 3'd0;
    localparam logic [2:0] SIM_ST_PASS    = 3'd1;
    localparam logic [2:0] SIM_ST_FAIL    = 3'd2;
    localparam logic [2:0] SIM_ST_TIMEOUT = 3'd3;
    localparam logic [2:0] SIM_ST_HANG    = 3'd4;

    // Controller FSM
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,   // CPU held in reset
        ST_RUN  = 2'd1,   // CPU running, monitors active
        ST_DONE = 2'd2    // verdict latched, everything frozen
    } state_t;

    // Byte address -> containing word address (byte offset dropped)
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_test_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_test_controller_if
//  Description : Snoop/verdict bundle between the CPU harness and the test
//                controller. The master side supplies the snooped CPU
//                fetch/data-memory signals; the slave side (the controller)
//                returns the CPU reset, verdict and console strobe.
//  Revision    : 1.0  initial release
// ============================================================================
interface sim_test_controller_if #(
    parameter int unsigned CNT_W = 32
);
    // Snooped CPU signals
    logic [31:0]      inst_addr;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wdata;
    logic [3:0]       dmem_wmask;
    logic             dmem_we;

    // Controller outputs
    logic             cpu_reset;
    logic             done;
    logic             pass;
    logic [2:0]       status;
    logic [30:0]      exit_code;
    logic [CNT_W-1:0] cycle_count;
    logic             console_valid;
    logic [7:0]       console_char;

    modport master (
        output inst_addr, dmem_addr, dmem_wdata, dmem_wmask, dmem_we,
        input  cpu_reset, done, pass, status, exit_code, cycle_count,
               console_valid, console_char
    );

    modport slave (
        input  inst_addr, dmem_addr, dmem_wdata, dmem_wmask, dmem_we,
        output cpu_reset, done, pass, status, exit_code, cycle_count,
               console_valid, console_char
    );
endinterface
`default_nettype wire

// File: rtl/sim_test_controller_stall_detector.sv
`default_nettype none
// ============================================================================
//  Module      : sim_stall_detector
//  Description : PC-stall (hang) detector. Counts consecutive enabled cycles
//                in which inst_addr equals its previous-cycle value; flags
//                hang on the cycle the count reaches STALL_LIMIT.
//                STALL_LIMIT = 0 disables the detector.
//  Ports       : clk, reset   clock / synchronous active-high reset
//                en           count only while the CPU is running
//                inst_addr    snooped fetch address
//                hang         combinational event, sampled by the parent FSM
//  Revision    : 1.0  initial release
// ============================================================================
module sim_stall_detector #(
    parameter int unsigned STALL_LIMIT = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        en,
    input  wire logic [31:0] inst_addr,
    output logic             hang
);
    localparam logic        c_ENABLE  = (STALL_LIMIT != 0);
    localparam int unsigned c_STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [c_STALL_W-1:0] c_STALL_LAST =
        c_STALL_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

    logic [31:0]          r_prev_addr;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 w_same;

    assign w_same = (inst_addr == r_prev_addr);

    // The previous address is tracked even while disabled so the very first
    // RUN cycle already compares against a real fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_addr <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_prev_addr <= inst_addr;
            if (!en || !w_same) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
            end
        end
    end

    // Fires in the cycle whose sample would bring the count to STALL_LIMIT.
    assign hang = c_ENABLE && en && w_same && (r_stall_cnt == c_STALL_LAST);

endmodule
`default_nettype wire

// File: rtl/sim_test_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sim_test_controller
//  Description : Simulation / self-test harness controller for rv32i_cpu.
//                Sequences the CPU reset, snoops data-memory stores for the
//                tohost exit word and console byte port, and runs a cycle
//                watchdog plus PC-stall detector. Latches a sticky verdict.
//  Ports       : clk, reset     clock / synchronous active-high reset
//                bus (slave)    inst_addr, dmem_addr/wdata/wmask/we in;
//                               cpu_reset, done, pass, status, exit_code,
//                               cycle_count, console_valid, console_char out
//  Revision    : 1.0  initial release
// ============================================================================
module sim_test_controller
    import sim_test_controller_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
    parameter int unsigned TIMEOUT      = 250000,
    parameter int unsigned STALL_LIMIT  = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    sim_test_controller_if.slave  bus
);
    localparam int unsigned c_HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST =
        c_HOLD_W'((RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1);
    localparam logic             c_WDOG_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [31:0] c_TOHOST_WORD  = word_addr(TOHOST_ADDR);
    localparam logic [31:0] c_CONSOLE_WORD = word_addr(CONSOLE_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [2:0]          r_status;
    logic [2:0]          w_status_nxt;
    logic [30:0]         r_exit_code;
    logic [30:0]         w_exit_nxt;
    logic                r_console_valid;
    logic [7:0]          r_console_char;

    logic                w_run;
    logic                w_wr_tohost;
    logic                w_wr_console;
    logic                w_timeout;
    logic                w_hang;

    // ------------------------------------------------------------------
    // PC-stall detector
    // ------------------------------------------------------------------
    sim_stall_detector #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk       (clk),
        .reset     (reset),
        .en        (w_run),
        .inst_addr (bus.inst_addr),
        .hang      (w_hang)
    );

    // ------------------------------------------------------------------
    // Event decode: all snoop/monitor events are qualified by RUN, so
    // HOLD and DONE ignore the bus entirely.
    // ------------------------------------------------------------------
    assign w_run = (r_state == ST_RUN);

    assign w_wr_tohost  = w_run && bus.dmem_we
                       && (word_addr(bus.dmem_addr) == c_TOHOST_WORD)
                       && (bus.dmem_wmask == 4'hF)
                       && bus.dmem_wdata[0];

    assign w_wr_console = w_run && bus.dmem_we
                       && (word_addr(bus.dmem_addr) == c_CONSOLE_WORD)
                       && bus.dmem_wmask[0];

    assign w_timeout = c_WDOG_EN && w_run && (r_cycle_cnt == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // FSM next-state / verdict logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_exit_nxt   = r_exit_code;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // tohost outranks hang, which outranks the watchdog
                if (w_wr_tohost) begin
                    w_state_nxt = ST_DONE;
                    if (bus.dmem_wdata == 32'd1) begin
                        w_status_nxt = SIM_ST_PASS;
                    end else begin
                        w_status_nxt = SIM_ST_FAIL;
                        w_exit_nxt   = bus.dmem_wdata[31:1];
                    end
                end else if (w_hang) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = SIM_ST_HANG;
                end else if (w_timeout) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = SIM_ST_TIMEOUT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, verdict registers and console strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt      <= '0;
            r_cycle_cnt     <= '0;
            r_status        <= SIM_ST_RUNNING;
            r_exit_code     <= '0;
            r_console_valid <= 1'b0;
            r_console_char  <= '0;
        end else begin
            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end
            // The verdict edge does not count, so cycle_count freezes at the
            // value seen in the cycle that produced the verdict.
            if (w_run && (w_state_nxt == ST_RUN)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            r_status        <= w_status_nxt;
            r_exit_code     <= w_exit_nxt;
            r_console_valid <= w_wr_console;
            if (w_wr_console) begin
                r_console_char <= bus.dmem_wdata[7:0];
            end
        end
    end

    // All outputs derive from registers only.
    assign bus.cpu_reset     = (r_state == ST_HOLD);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.pass          = (r_state == ST_DONE) && (r_status == SIM_ST_PASS);
    assign bus.status        = r_status;
    assign bus.exit_code     = r_exit_code;
    assign bus.cycle_count   = r_cycle_cnt;
    assign bus.console_valid = r_console_valid;
    assign bus.console_char  = r_console_char;

endmodule
`default_nettype wire

// File: tb/tb_sim_test_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_test_controller
//  Description : Directed self-checking bench for sim_test_controller.
//                dut_a: RESET_CYCLES=16, default watchdog/stall limits.
//                dut_b: RESET_CYCLES=4, TIMEOUT=50, STALL_LIMIT=8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sim_test_controller;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic [3:0]  dmem_wmask = 4'h0;
    logic        dmem_we = 1'b0;
    logic        pc_inc = 1'b1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sim_test_controller_if #(.CNT_W(32)) bus_a ();
    sim_test_controller_if #(.CNT_W(32)) bus_b ();

    assign bus_a.inst_addr  = inst_addr;
    assign bus_a.dmem_addr  = dmem_addr;
    assign bus_a.dmem_wdata = dmem_wdata;
    assign bus_a.dmem_wmask = dmem_wmask;
    assign bus_a.dmem_we    = dmem_we;
    assign bus_b.inst_addr  = inst_addr;
    assign bus_b.dmem_addr  = dmem_addr;
    assign bus_b.dmem_wdata = dmem_wdata;
    assign bus_b.dmem_wmask = dmem_wmask;
    assign bus_b.dmem_we    = dmem_we;

    sim_test_controller #(
        .RESET_CYCLES (16),
        .TOHOST_ADDR  (32'h0000_1000),
        .CONSOLE_ADDR (32'h0000_1004),
        .TIMEOUT      (250000),
        .STALL_LIMIT  (64),
        .CNT_W        (32)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    sim_test_controller #(
        .RESET_CYCLES (4),
        .TOHOST_ADDR  (32'h0000_1000),
        .CONSOLE_ADDR (32'h0000_1004),
        .TIMEOUT      (50),
        .STALL_LIMIT  (8),
        .CNT_W        (32)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    // One clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pc_inc) inst_addr = inst_addr + 32'd4;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dmem_addr  = a;
        dmem_wdata = d;
        dmem_wmask = m;
        dmem_we    = 1'b1;
        step();
        dmem_we    = 1'b0;
    endtask

    // Reset dut_a and wait (bounded) until it is in RUN.
    task automatic start_a();
        int n;
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        n = 0;
        while (bus_a.cpu_reset && n < 40) begin step(); n++; end
        total++;
        if (bus_a.cpu_reset !== 1'b0) begin
            bad++; $display("FAIL start_a_timeout: cpu_reset=%b required 0", bus_a.cpu_reset);
        end
    endtask

    task automatic start_b();
        int n;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        n = 0;
        while (bus_b.cpu_reset && n < 40) begin step(); n++; end
        total++;
        if (bus_b.cpu_reset !== 1'b0) begin
            bad++; $display("FAIL start_b_timeout: cpu_reset=%b required 0", bus_b.cpu_reset);
        end
    endtask

    task automatic test_reset();
        int n;
        reset_a = 1'b1;
        step();
        total++;
        if ({bus_a.cpu_reset, bus_a.done, bus_a.pass, bus_a.console_valid} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags: cpu_reset/done/pass/cvalid=%b required 1000",
                {bus_a.cpu_reset, bus_a.done, bus_a.pass, bus_a.console_valid});
        end
        total++;
        if (bus_a.status !== 3'd0 || bus_a.exit_code !== 31'd0 || bus_a.cycle_count !== 32'd0) begin
            bad++; $display("FAIL reset_values: status=%0d exit=%0d cycles=%0d required 0 0 0",
                bus_a.status, bus_a.exit_code, bus_a.cycle_count);
        end
        reset_a = 1'b0;
        n = 0;
        while (bus_a.cpu_reset && n < 40) begin step(); n++; end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL reset_hold_len: cpu_reset high for %0d clocks required 16", n);
        end
        total++;
        if (bus_a.status !== 3'd0 || bus_a.cycle_count !== 32'd0) begin
            bad++; $display("FAIL run_entry: status=%0d cycles=%0d required 0 0",
                bus_a.status, bus_a.cycle_count);
        end
        step(); step();
        total++;
        if (bus_a.cycle_count !== 32'd2) begin
            bad++; $display("FAIL run_count: cycles=%0d required 2", bus_a.cycle_count);
        end
    endtask

    task automatic test_pass();
        start_a();
        repeat (100) step();
        store(32'h0000_1000, 32'h1, 4'hF);
        total++;
        if ({bus_a.done, bus_a.pass} !== 2'b11 || bus_a.status !== 3'd1) begin
            bad++; $display("FAIL pass_verdict: done/pass=%b status=%0d required 11 1",
                {bus_a.done, bus_a.pass}, bus_a.status);
        end
        total++;
        if (bus_a.cycle_count !== 32'd100) begin
            bad++; $display("FAIL pass_cycles: cycles=%0d required 100", bus_a.cycle_count);
        end
        repeat (5) step();
        store(32'h0000_1000, 32'h7, 4'hF);
        total++;
        if (bus_a.status !== 3'd1 || bus_a.cycle_count !== 32'd100 || bus_a.done !== 1'b1) begin
            bad++; $display("FAIL pass_sticky: status=%0d cycles=%0d done=%b required 1 100 1",
                bus_a.status, bus_a.cycle_count, bus_a.done);
        end
    endtask

    task automatic test_fail();
        start_a();
        store(32'h0000_1000, 32'h7, 4'h1);
        store(32'h0000_1000, 32'h2, 4'hF);
        total++;
        if (bus_a.done !== 1'b0 || bus_a.status !== 3'd0) begin
            bad++; $display("FAIL fail_ignored: done=%b status=%0d required 0 0",
                bus_a.done, bus_a.status);
        end
        // byte offset within the tohost word still matches
        store(32'h0000_1003, 32'h7, 4'hF);
        total++;
        if (bus_a.status !== 3'd2 || bus_a.exit_code !== 31'd3 || bus_a.pass !== 1'b0 || bus_a.done !== 1'b1) begin
            bad++; $display("FAIL fail_verdict: status=%0d exit=%0d pass=%b done=%b required 2 3 0 1",
                bus_a.status, bus_a.exit_code, bus_a.pass, bus_a.done);
        end
    endtask

    task automatic test_console();
        start_a();
        store(32'h0000_1004, 32'h0000_0048, 4'h1);
        total++;
        if (bus_a.console_valid !== 1'b1 || bus_a.console_char !== 8'h48) begin
            bad++; $display("FAIL console_H: valid=%b char=%h required 1 48",
                bus_a.console_valid, bus_a.console_char);
        end
        store(32'h0000_1004, 32'h0000_0069, 4'h1);
        total++;
        if (bus_a.console_valid !== 1'b1 || bus_a.console_char !== 8'h69) begin
            bad++; $display("FAIL console_i: valid=%b char=%h required 1 69",
                bus_a.console_valid, bus_a.console_char);
        end
        step();
        total++;
        if (bus_a.console_valid !== 1'b0) begin
            bad++; $display("FAIL console_strobe_len: valid=%b required 0", bus_a.console_valid);
        end
        store(32'h0000_1004, 32'h0000_2100, 4'h2);
        total++;
        if (bus_a.console_valid !== 1'b0 || bus_a.done !== 1'b0) begin
            bad++; $display("FAIL console_lane: valid=%b done=%b required 0 0",
                bus_a.console_valid, bus_a.done);
        end
    endtask

    task automatic test_timeout();
        int n;
        pc_inc = 1'b1;
        start_b();
        n = 0;
        while (!bus_b.done && n < 100) begin step(); n++; end
        total++;
        if (bus_b.status !== 3'd3 || bus_b.cycle_count !== 32'd49 || n != 50 || bus_b.pass !== 1'b0) begin
            bad++; $display("FAIL timeout: status=%0d cycles=%0d clocks=%0d pass=%b required 3 49 50 0",
                bus_b.status, bus_b.cycle_count, n, bus_b.pass);
        end
    endtask

    task automatic test_hang();
        int n;
        pc_inc = 1'b0;
        start_b();
        n = 0;
        while (!bus_b.done && n < 40) begin step(); n++; end
        total++;
        if (bus_b.status !== 3'd4 || n != 8 || bus_b.cycle_count !== 32'd7) begin
            bad++; $display("FAIL hang: status=%0d clocks=%0d cycles=%0d required 4 8 7",
                bus_b.status, n, bus_b.cycle_count);
        end
        pc_inc = 1'b1;
    endtask

    task automatic test_reset_mid();
        start_a();
        repeat (5) step();
        reset_a = 1'b1;
        step();
        total++;
        if (bus_a.cpu_reset !== 1'b1 || bus_a.cycle_count !== 32'd0 || bus_a.done !== 1'b0) begin
            bad++; $display("FAIL reset_in_run: cpu_reset=%b cycles=%0d done=%b required 1 0 0",
                bus_a.cpu_reset, bus_a.cycle_count, bus_a.done);
        end
        start_a();
        store(32'h0000_1000, 32'h7, 4'hF);
        store(32'h0000_1004, 32'h41, 4'h1);
        total++;
        if (bus_a.console_valid !== 1'b0 || bus_a.exit_code !== 31'd3) begin
            bad++; $display("FAIL done_ignores_bus: valid=%b exit=%0d required 0 3",
                bus_a.console_valid, bus_a.exit_code);
        end
        reset_a = 1'b1;
        step();
        total++;
        if ({bus_a.cpu_reset, bus_a.done, bus_a.pass} !== 3'b100 || bus_a.status !== 3'd0
            || bus_a.exit_code !== 31'd0 || bus_a.console_char !== 8'h00) begin
            bad++; $display("FAIL reset_in_done: rst/done/pass=%b status=%0d exit=%0d char=%h required 100 0 0 00",
                {bus_a.cpu_reset, bus_a.done, bus_a.pass}, bus_a.status, bus_a.exit_code, bus_a.console_char);
        end
        reset_a = 1'b0;
    endtask

    task automatic test_priority();
        pc_inc = 1'b1;
        start_b();
        repeat (49) step();
        store(32'h0000_1000, 32'h1, 4'hF);
        total++;
        if (bus_b.status !== 3'd1 || bus_b.pass !== 1'b1 || bus_b.cycle_count !== 32'd49) begin
            bad++; $display("FAIL prio_tohost_timeout: status=%0d pass=%b cycles=%0d required 1 1 49",
                bus_b.status, bus_b.pass, bus_b.cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_console();
        test_timeout();
        test_hang();
        test_reset_mid();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
